// File: rtl/sophon_pkg.sv
// rtl/sophon_pkg.sv - shared LSU request/response types and arbiter owner encoding
package sophon_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  strb;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CORE = 2'd1,
    OWNER_EXT  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/dram_addr_win_chk.sv
// rtl/dram_addr_win_chk.sv - flags whether a byte address falls inside the SRAM window
module dram_addr_win_chk #(
  parameter logic [31:0] DRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] DRAM_SIZE = 32'h0001_0000
) (
  input  logic [31:0] addr,
  output logic        in_win
);

  // Unsigned wrap makes addresses below the base land far above the size.
  assign in_win = (addr - DRAM_BASE) < DRAM_SIZE;

endmodule

// File: rtl/dram_starve_arbiter.sv
// rtl/dram_starve_arbiter.sv - ext-priority SRAM arbiter with core starvation guard
module dram_starve_arbiter
  import sophon_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] DRAM_SIZE = 32'h0001_0000,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  lsu_req_t    core_dram_req,
  output lsu_ack_t    core_dram_ack,
  input  lsu_req_t    ext_dram_req,
  output lsu_ack_t    ext_dram_ack,
  output logic        dram_req,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic        dram_we,
  output logic [3:0]  dram_be,
  input  logic [31:0] dram_rdata
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic       core_in_win;
  logic       ext_in_win;
  logic       grant_core;
  logic       grant_ext;
  logic       sel_in_win;
  lsu_req_t   sel_req;
  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  arb_owner_e rsp_owner_q;
  arb_owner_e rsp_owner_d;

  dram_addr_win_chk #(.DRAM_BASE(DRAM_BASE), .DRAM_SIZE(DRAM_SIZE)) u_core_win (
    .addr   (core_dram_req.addr),
    .in_win (core_in_win)
  );

  dram_addr_win_chk #(.DRAM_BASE(DRAM_BASE), .DRAM_SIZE(DRAM_SIZE)) u_ext_win (
    .addr   (ext_dram_req.addr),
    .in_win (ext_in_win)
  );

  // Same-cycle grant; ext wins unless core has waited MAX_WAIT cycles. Held off during reset.
  always_comb begin
    grant_core = rst_ni && core_dram_req.req &&
                 (!ext_dram_req.req || (starve_cnt_q == MAX_W));
    grant_ext  = rst_ni && ext_dram_req.req && !grant_core;
    sel_req    = grant_core ? core_dram_req : ext_dram_req;
    sel_in_win = grant_core ? core_in_win : ext_in_win;
  end

  // Drive the SRAM only for in-window grants; everything else parks at zero.
  always_comb begin
    dram_req   = 1'b0;
    dram_addr  = 32'h0;
    dram_wdata = 32'h0;
    dram_we    = 1'b0;
    dram_be    = 4'h0;
    if ((grant_core || grant_ext) && sel_in_win) begin
      dram_req   = 1'b1;
      dram_addr  = sel_req.addr;
      dram_wdata = sel_req.wdata;
      dram_we    = sel_req.we;
      dram_be    = sel_req.strb;
    end
  end

  // Acks in the grant cycle; rdata steered by the owner of last cycle's read.
  always_comb begin
    core_dram_ack.ack   = grant_core;
    core_dram_ack.error = grant_core && !core_in_win;
    core_dram_ack.rdata = (rsp_owner_q == OWNER_CORE) ? dram_rdata : 32'h0;
    ext_dram_ack.ack    = grant_ext;
    ext_dram_ack.error  = grant_ext && !ext_in_win;
    ext_dram_ack.rdata  = (rsp_owner_q == OWNER_EXT) ? dram_rdata : 32'h0;
  end

  // Next-state for the starvation counter and the read-response owner.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (core_dram_req.req && !grant_core) begin
      starve_cnt_d = (starve_cnt_q >= MAX_W) ? MAX_W : starve_cnt_q + 4'd1;
    end
    rsp_owner_d = OWNER_NONE;
    if (dram_req && !dram_we) begin
      rsp_owner_d = grant_core ? OWNER_CORE : OWNER_EXT;
    end
  end

  // State registers; reset drops any pending read response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= 4'd0;
      rsp_owner_q  <= OWNER_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
    end
  end

endmodule

// File: tb/tb_dram_starve_arbiter.sv
// tb/tb_dram_starve_arbiter.sv - directed self-checking bench for dram_starve_arbiter
module tb_dram_starve_arbiter;
  import sophon_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  lsu_req_t    core_dram_req;
  lsu_ack_t    core_dram_ack;
  lsu_req_t    ext_dram_req;
  lsu_ack_t    ext_dram_ack;
  logic        dram_req;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_we;
  logic [3:0]  dram_be;
  logic [31:0] dram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  dram_starve_arbiter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .core_dram_req (core_dram_req),
    .core_dram_ack (core_dram_ack),
    .ext_dram_req  (ext_dram_req),
    .ext_dram_ack  (ext_dram_ack),
    .dram_req      (dram_req),
    .dram_addr     (dram_addr),
    .dram_wdata    (dram_wdata),
    .dram_we       (dram_we),
    .dram_be       (dram_be),
    .dram_rdata    (dram_rdata)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic lsu_req_t mk(input logic req, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic we,
                                  input logic [3:0] strb);
    lsu_req_t r;
    r.req   = req;
    r.addr  = addr;
    r.wdata = wdata;
    r.we    = we;
    r.strb  = strb;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    lsu_req_t idle;
    logic     exp_core;
    idle = mk(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);

    // Reset state
    rst_ni        = 1'b0;
    core_dram_req = idle;
    ext_dram_req  = idle;
    dram_rdata    = 32'hFFFF_FFFF;
    settle();
    chk("rst_core_ack", {31'h0, core_dram_ack.ack}, 32'h0);
    chk("rst_ext_ack", {31'h0, ext_dram_ack.ack}, 32'h0);
    chk("rst_dram_req", {31'h0, dram_req}, 32'h0);
    chk("rst_core_rdata", core_dram_ack.rdata, 32'h0);
    chk("rst_ext_rdata", ext_dram_ack.rdata, 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    settle();
    chk("idle_starve", {28'h0, dut.starve_cnt_q}, 32'h0);

    // Core-only read
    tick();
    core_dram_req = mk(1'b1, 32'h8000_0010, 32'h0, 1'b0, 4'hF);
    settle();
    chk("t1_core_ack", {31'h0, core_dram_ack.ack}, 32'h1);
    chk("t1_core_err", {31'h0, core_dram_ack.error}, 32'h0);
    chk("t1_ext_ack", {31'h0, ext_dram_ack.ack}, 32'h0);
    chk("t1_dram_req", {31'h0, dram_req}, 32'h1);
    chk("t1_dram_addr", dram_addr, 32'h8000_0010);
    chk("t1_dram_we", {31'h0, dram_we}, 32'h0);
    tick();
    core_dram_req = idle;
    dram_rdata    = 32'hDEAD_BEEF;
    settle();
    chk("t1_core_rdata", core_dram_ack.rdata, 32'hDEAD_BEEF);
    chk("t1_ext_rdata", ext_dram_ack.rdata, 32'h0);
    chk("t1_core_ack_off", {31'h0, core_dram_ack.ack}, 32'h0);

    // Both requesting continuously: ext x4, core x1, repeating
    tick();
    core_dram_req = mk(1'b1, 32'h8000_0100, 32'h0, 1'b0, 4'hF);
    ext_dram_req  = mk(1'b1, 32'h8000_0200, 32'h0, 1'b0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      dram_rdata = 32'hA000_0000 + 32'(i);
      settle();
      exp_core = ((i % 5) == 4);
      chk($sformatf("t2_core_ack_%0d", i), {31'h0, core_dram_ack.ack}, {31'h0, exp_core});
      chk($sformatf("t2_ext_ack_%0d", i), {31'h0, ext_dram_ack.ack}, {31'h0, !exp_core});
      chk($sformatf("t2_addr_%0d", i), dram_addr, exp_core ? 32'h8000_0100 : 32'h8000_0200);
      chk($sformatf("t2_starve_%0d", i), {28'h0, dut.starve_cnt_q}, 32'(i % 5));
      if (i == 0) begin
        chk("t2_core_rdata_0", core_dram_ack.rdata, 32'h0);
        chk("t2_ext_rdata_0", ext_dram_ack.rdata, 32'h0);
      end else if (((i - 1) % 5) == 4) begin
        chk($sformatf("t2_core_rdata_%0d", i), core_dram_ack.rdata, 32'hA000_0000 + 32'(i));
        chk($sformatf("t2_ext_rdata_%0d", i), ext_dram_ack.rdata, 32'h0);
      end else begin
        chk($sformatf("t2_core_rdata_%0d", i), core_dram_ack.rdata, 32'h0);
        chk($sformatf("t2_ext_rdata_%0d", i), ext_dram_ack.rdata, 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    core_dram_req = idle;
    ext_dram_req  = idle;
    dram_rdata    = 32'hB0B0_B0B0;
    settle();
    chk("t2_tail_core_rdata", core_dram_ack.rdata, 32'hB0B0_B0B0);
    chk("t2_tail_ext_rdata", ext_dram_ack.rdata, 32'h0);
    chk("t2_tail_starve", {28'h0, dut.starve_cnt_q}, 32'h0);

    // Ext write beats core read; write yields no rdata routing
    tick();
    ext_dram_req  = mk(1'b1, 32'h8000_0020, 32'h1234_5678, 1'b1, 4'b0011);
    core_dram_req = mk(1'b1, 32'h8000_0030, 32'h0, 1'b0, 4'hF);
    settle();
    chk("t3_ext_ack", {31'h0, ext_dram_ack.ack}, 32'h1);
    chk("t3_core_ack", {31'h0, core_dram_ack.ack}, 32'h0);
    chk("t3_dram_we", {31'h0, dram_we}, 32'h1);
    chk("t3_dram_be", {28'h0, dram_be}, 32'h3);
    chk("t3_dram_wdata", dram_wdata, 32'h1234_5678);
    tick();
    ext_dram_req = idle;
    dram_rdata   = 32'hFFFF_FFFF;
    settle();
    chk("t3_core_ack2", {31'h0, core_dram_ack.ack}, 32'h1);
    chk("t3_core_rdata_none", core_dram_ack.rdata, 32'h0);
    chk("t3_ext_rdata_none", ext_dram_ack.rdata, 32'h0);
    tick();
    core_dram_req = idle;
    dram_rdata    = 32'h5555_AAAA;
    settle();
    chk("t3_core_rdata", core_dram_ack.rdata, 32'h5555_AAAA);

    // Out-of-window core request
    tick();
    core_dram_req = mk(1'b1, 32'h0000_0100, 32'h0, 1'b0, 4'hF);
    settle();
    chk("t4_core_ack", {31'h0, core_dram_ack.ack}, 32'h1);
    chk("t4_core_err", {31'h0, core_dram_ack.error}, 32'h1);
    chk("t4_dram_req", {31'h0, dram_req}, 32'h0);
    chk("t4_dram_addr", dram_addr, 32'h0);
    tick();
    core_dram_req = idle;
    dram_rdata    = 32'hCAFE_F00D;
    settle();
    chk("t4_core_rdata", core_dram_ack.rdata, 32'h0);
    chk("t4_ext_rdata", ext_dram_ack.rdata, 32'h0);

    // Window edges on ext: last word inside, first byte past the end
    tick();
    ext_dram_req = mk(1'b1, 32'h8000_FFFC, 32'h0, 1'b0, 4'hF);
    settle();
    chk("t4_edge_in_req", {31'h0, dram_req}, 32'h1);
    chk("t4_edge_in_err", {31'h0, ext_dram_ack.error}, 32'h0);
    tick();
    ext_dram_req = mk(1'b1, 32'h8001_0000, 32'h0, 1'b0, 4'hF);
    settle();
    chk("t4_edge_out_ack", {31'h0, ext_dram_ack.ack}, 32'h1);
    chk("t4_edge_out_err", {31'h0, ext_dram_ack.error}, 32'h1);
    chk("t4_edge_out_req", {31'h0, dram_req}, 32'h0);
    tick();
    ext_dram_req = idle;
    settle();
    chk("t4_edge_out_rdata", ext_dram_ack.rdata, 32'h0);

    // Back-to-back reads: ext then core
    tick();
    ext_dram_req = mk(1'b1, 32'h8000_0000, 32'h0, 1'b0, 4'hF);
    settle();
    chk("t5_ext_addr", dram_addr, 32'h8000_0000);
    tick();
    ext_dram_req  = idle;
    core_dram_req = mk(1'b1, 32'h8000_0004, 32'h0, 1'b0, 4'hF);
    dram_rdata    = 32'h1111_1111;
    settle();
    chk("t5_ext_rdata", ext_dram_ack.rdata, 32'h1111_1111);
    chk("t5_core_rdata0", core_dram_ack.rdata, 32'h0);
    chk("t5_core_ack", {31'h0, core_dram_ack.ack}, 32'h1);
    chk("t5_core_addr", dram_addr, 32'h8000_0004);
    tick();
    core_dram_req = idle;
    dram_rdata    = 32'h2222_2222;
    settle();
    chk("t5_core_rdata", core_dram_ack.rdata, 32'h2222_2222);
    chk("t5_ext_rdata0", ext_dram_ack.rdata, 32'h0);

    // Reset asserted the cycle after a read grant
    tick();
    ext_dram_req  = mk(1'b1, 32'h8000_0008, 32'h0, 1'b0, 4'hF);
    core_dram_req = mk(1'b1, 32'h8000_000C, 32'h0, 1'b0, 4'hF);
    settle();
    chk("t6_ext_ack", {31'h0, ext_dram_ack.ack}, 32'h1);
    tick();
    dram_rdata = 32'h3333_3333;
    settle();
    chk("t6_pre_ext_rdata", ext_dram_ack.rdata, 32'h3333_3333);
    chk("t6_pre_starve", {28'h0, dut.starve_cnt_q}, 32'h1);
    rst_ni = 1'b0;
    settle();
    chk("t6_rst_core_ack", {31'h0, core_dram_ack.ack}, 32'h0);
    chk("t6_rst_ext_ack", {31'h0, ext_dram_ack.ack}, 32'h0);
    chk("t6_rst_dram_req", {31'h0, dram_req}, 32'h0);
    chk("t6_rst_ext_rdata", ext_dram_ack.rdata, 32'h0);
    chk("t6_rst_core_rdata", core_dram_ack.rdata, 32'h0);
    chk("t6_rst_starve", {28'h0, dut.starve_cnt_q}, 32'h0);
    core_dram_req = idle;
    ext_dram_req  = idle;
    tick();
    rst_ni = 1'b1;
    settle();
    chk("t6_post_ext_rdata", ext_dram_ack.rdata, 32'h0);
    chk("t6_post_core_rdata", core_dram_ack.rdata, 32'h0);
    tick();
    settle();
    chk("t6_post2_ext_rdata", ext_dram_ack.rdata, 32'h0);
    chk("t6_post2_starve", {28'h0, dut.starve_cnt_q}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
